// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared opcode constants, control enums and the decoded control bundle
// Used by instr_decode (produces ctrl_bundle_t) and decode_ctrl_pipe (registers it).
package ctrl_pkg;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_M      = 7'b0000001;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010, ALU_OR  = 4'b0011,
        ALU_XOR  = 4'b0100, ALU_SLL = 4'b0101, ALU_SRL = 4'b0110, ALU_SRA = 4'b0111,
        ALU_SLT  = 4'b1000, ALU_SLTU = 4'b1001, ALU_LUI = 4'b1111
    } alu_op_e;
    typedef enum logic [2:0] {IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011, IMM_U = 3'b100} imm_src_e;
    typedef enum logic [1:0] {RES_ALU = 2'b00, RES_MEM = 2'b01, RES_PC4 = 2'b10, RES_MD = 2'b11} result_src_e;
    typedef enum logic [1:0] {JMP_NONE = 2'b00, JMP_JAL = 2'b01, JMP_JALR = 2'b10} jump_e;
    typedef struct packed {
        logic        reg_write, mem_write, branch, load, store, alu_src_a, alu_src_b;
        alu_op_e     alu_control;
        result_src_e result_src;
        logic [2:0]  branch_type;
        jump_e       jump;
        imm_src_e    imm_src;
        logic [2:0]  addr_ctrl;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  muldiv_op;
    } ctrl_bundle_t;
    // alt selects sub/sra over add/srl
    function automatic alu_op_e alu_of(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction
endpackage

// File: rtl/instr_decode.sv
// instr_decode: combinational RV32I(+M) decoder into ctrl_bundle_t
// Ports: i_instr (32-bit instruction) -> o_bundle (control bundle),
//        o_is_muldiv (legal RV32M op), o_illegal (unknown opcode / bad funct7 / disabled M)
import ctrl_pkg::*;
module instr_decode #(
    parameter bit ENABLE_M = 1'b1
) (
    input  logic [31:0]  i_instr,
    output ctrl_bundle_t o_bundle,
    output logic         o_is_muldiv,
    output logic         o_illegal
);
    logic [6:0] w_op, w_f7;
    logic [2:0] w_f3;
    assign w_op = i_instr[6:0];
    assign w_f3 = i_instr[14:12];
    assign w_f7 = i_instr[31:25];
    always_comb begin
        o_bundle = '0;
        o_bundle.rd = i_instr[11:7];
        o_bundle.rs1 = i_instr[19:15];
        o_bundle.rs2 = i_instr[24:20];
        o_is_muldiv = 1'b0;
        o_illegal = 1'b0;
        case (w_op)
            OP_R: begin
                if (w_f7 == F7_M) begin
                    o_illegal = !ENABLE_M;
                    o_is_muldiv = ENABLE_M;
                    o_bundle.reg_write = ENABLE_M;
                    o_bundle.result_src = ENABLE_M ? RES_MD : RES_ALU;
                    o_bundle.muldiv_op = ENABLE_M ? w_f3 : 3'b000;
                end else if (w_f7 == F7_BASE || (w_f7 == F7_ALT && (w_f3 == 3'b000 || w_f3 == 3'b101))) begin
                    o_bundle.reg_write = 1'b1;
                    o_bundle.alu_control = alu_of(w_f3, w_f7[5]);
                end else o_illegal = 1'b1;
            end
            OP_I: begin
                // only the shift-immediates carry a funct7 field
                if ((w_f3 == 3'b001 && w_f7 != F7_BASE) || (w_f3 == 3'b101 && w_f7 != F7_BASE && w_f7 != F7_ALT)) o_illegal = 1'b1;
                else begin
                    o_bundle.reg_write = 1'b1;
                    o_bundle.alu_src_b = 1'b1;
                    o_bundle.alu_control = alu_of(w_f3, w_f3 == 3'b101 && w_f7[5]);
                end
            end
            OP_LOAD: begin
                o_bundle.reg_write = 1'b1;
                o_bundle.load = 1'b1;
                o_bundle.alu_src_b = 1'b1;
                o_bundle.result_src = RES_MEM;
                o_bundle.addr_ctrl = w_f3;
            end
            OP_STORE: begin
                o_bundle.mem_write = 1'b1;
                o_bundle.store = 1'b1;
                o_bundle.alu_src_b = 1'b1;
                o_bundle.imm_src = IMM_S;
                o_bundle.addr_ctrl = w_f3;
            end
            OP_BRANCH: begin
                o_bundle.branch = 1'b1;
                o_bundle.imm_src = IMM_B;
                o_bundle.branch_type = w_f3;
                o_bundle.alu_control = w_f3[2:1] == 2'b11 ? ALU_SLTU : w_f3[2:1] == 2'b10 ? ALU_SLT : ALU_SUB;
            end
            OP_JAL: begin
                o_bundle.reg_write = 1'b1;
                o_bundle.jump = JMP_JAL;
                o_bundle.imm_src = IMM_J;
                o_bundle.result_src = RES_PC4;
            end
            OP_JALR: begin
                o_bundle.reg_write = 1'b1;
                o_bundle.jump = JMP_JALR;
                o_bundle.alu_src_b = 1'b1;
                o_bundle.result_src = RES_PC4;
            end
            OP_LUI: begin
                o_bundle.reg_write = 1'b1;
                o_bundle.alu_src_b = 1'b1;
                o_bundle.alu_control = ALU_LUI;
                o_bundle.imm_src = IMM_U;
            end
            OP_AUIPC: begin
                o_bundle.reg_write = 1'b1;
                o_bundle.alu_src_a = 1'b1;
                o_bundle.alu_src_b = 1'b1;
                o_bundle.imm_src = IMM_U;
            end
            default: o_illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/decode_ctrl_pipe.sv
// decode_ctrl_pipe: registered decode stage (ID/EX control register) with stall/flush and mul/div sequencing
// Inputs: clk, rst (sync, active-high), instr_i/instr_valid_i from IF/ID, stall_i, flush_i.
// Outputs: id_ready_o (combinational accept), ex_valid_o + registered control bundle,
//          muldiv_start_o/muldiv_abort_o pulses, illegal_o, busy_o (mul/div in flight).
import ctrl_pkg::*;
module decode_ctrl_pipe #(
    parameter bit ENABLE_M   = 1'b1,
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_i,
    input  logic        instr_valid_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic        id_ready_o,
    output logic        ex_valid_o,
    output logic        reg_write_o,
    output logic        mem_write_o,
    output logic        branch_o,
    output logic        load_o,
    output logic        store_o,
    output logic        alu_src_a_o,
    output logic        alu_src_b_o,
    output logic [3:0]  alu_control_o,
    output logic [1:0]  result_src_o,
    output logic [2:0]  branch_type_o,
    output logic [1:0]  jump_o,
    output logic [2:0]  imm_src_o,
    output logic [2:0]  addr_ctrl_o,
    output logic [4:0]  rd_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [2:0]  muldiv_op_o,
    output logic        muldiv_start_o,
    output logic        muldiv_abort_o,
    output logic        illegal_o,
    output logic        busy_o
);
    localparam int MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W = $clog2(MAX_LAT) + 1;
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_CYCLES - 1);
    typedef enum logic {IDLE, MD_BUSY} state_e;
    state_e           r_state, w_state_n;
    logic [CNT_W-1:0] r_cnt, w_cnt_n;
    ctrl_bundle_t     r_bundle, w_bundle_n, w_bundle;
    logic             r_ex_valid, w_ex_valid_n, r_illegal, w_illegal_n;
    logic             r_start, w_start_n, r_abort, w_abort_n;
    logic             w_is_md, w_illegal;
    instr_decode #(.ENABLE_M(ENABLE_M)) u_dec (
        .i_instr     (instr_i),
        .o_bundle    (w_bundle),
        .o_is_muldiv (w_is_md),
        .o_illegal   (w_illegal)
    );
    always_comb begin
        w_state_n = r_state;
        w_cnt_n = r_cnt;
        w_bundle_n = r_bundle;
        w_ex_valid_n = r_ex_valid;
        w_illegal_n = r_illegal;
        w_start_n = 1'b0;
        w_abort_n = 1'b0;
        if (flush_i) begin
            w_state_n = IDLE;
            w_cnt_n = '0;
            w_ex_valid_n = 1'b0;
            w_illegal_n = 1'b0;
            w_abort_n = r_state == MD_BUSY;
        end else if (r_state == IDLE) begin
            if (!stall_i) begin
                // M ops stay invalid to EX until the counter expires
                w_ex_valid_n = instr_valid_i && !w_is_md;
                w_illegal_n = instr_valid_i && w_illegal;
                if (instr_valid_i) begin
                    w_bundle_n = w_bundle;
                    w_start_n = w_is_md;
                    w_state_n = w_is_md ? MD_BUSY : IDLE;
                    if (w_is_md) w_cnt_n = instr_i[14] ? DIV_CNT : MUL_CNT;
                end
            end
        end else if (r_cnt != '0) w_cnt_n = r_cnt - CNT_W'(1);
        else if (!stall_i) begin
            w_state_n = IDLE;
            w_ex_valid_n = 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt <= '0;
            r_bundle <= '0;
            r_ex_valid <= 1'b0;
            r_illegal <= 1'b0;
            r_start <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt <= w_cnt_n;
            r_bundle <= w_bundle_n;
            r_ex_valid <= w_ex_valid_n;
            r_illegal <= w_illegal_n;
            r_start <= w_start_n;
            r_abort <= w_abort_n;
        end
    end
    assign id_ready_o = !rst && r_state == IDLE && !stall_i && !flush_i;
    assign ex_valid_o = r_ex_valid;
    assign reg_write_o = r_bundle.reg_write && r_ex_valid;
    assign mem_write_o = r_bundle.mem_write && r_ex_valid;
    assign branch_o = r_bundle.branch && r_ex_valid;
    assign load_o = r_bundle.load && r_ex_valid;
    assign store_o = r_bundle.store && r_ex_valid;
    assign jump_o = r_bundle.jump & {2{r_ex_valid}};
    assign alu_src_a_o = r_bundle.alu_src_a;
    assign alu_src_b_o = r_bundle.alu_src_b;
    assign alu_control_o = r_bundle.alu_control;
    assign result_src_o = r_bundle.result_src;
    assign branch_type_o = r_bundle.branch_type;
    assign imm_src_o = r_bundle.imm_src;
    assign addr_ctrl_o = r_bundle.addr_ctrl;
    assign rd_o = r_bundle.rd;
    assign rs1_o = r_bundle.rs1;
    assign rs2_o = r_bundle.rs2;
    assign muldiv_op_o = r_bundle.muldiv_op;
    assign muldiv_start_o = r_start;
    assign muldiv_abort_o = r_abort;
    assign illegal_o = r_illegal;
    assign busy_o = r_state == MD_BUSY;
endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// tb_decode_ctrl_pipe: scoreboard bench for decode_ctrl_pipe (plus an ENABLE_M=0 instance)
module tb_decode_ctrl_pipe;
    logic clk = 1'b0, rst = 1'b1, instr_valid_i = 1'b0, stall_i = 1'b0, flush_i = 1'b0;
    logic [31:0] instr_i = 32'h0;
    logic id_ready_o, ex_valid_o, reg_write_o, mem_write_o, branch_o, load_o, store_o, alu_src_a_o, alu_src_b_o;
    logic [3:0] alu_control_o;
    logic [1:0] result_src_o, jump_o;
    logic [2:0] branch_type_o, imm_src_o, addr_ctrl_o, muldiv_op_o;
    logic [4:0] rd_o, rs1_o, rs2_o;
    logic muldiv_start_o, muldiv_abort_o, illegal_o, busy_o;
    logic n_rdy, n_ev, n_rw, n_mw, n_br, n_ld, n_st, n_sa, n_sb, n_start, n_abort, n_ill, n_busy;
    logic [3:0] n_alu;
    logic [1:0] n_res, n_jmp;
    logic [2:0] n_bt, n_imm, n_ac, n_mop;
    logic [4:0] n_rd, n_rs1, n_rs2;
    logic [46:0] all_o;
    int n_checks = 0, n_errors = 0;
    logic held = 1'b0;
    typedef struct {
        string nm; logic [31:0] ins; logic [6:0] f; logic [3:0] alu; logic [1:0] res; logic [2:0] bt;
        logic [1:0] jmp; logic [2:0] imm; logic [2:0] ac; logic [4:0] rd, rs1, rs2; logic [2:0] mop; logic ill;
    } exp_t;
    exp_t q[$];
    exp_t tbl[12];
    exp_t m_e;

    always #5 clk = ~clk;

    decode_ctrl_pipe dut (
        .clk(clk), .rst(rst), .instr_i(instr_i), .instr_valid_i(instr_valid_i), .stall_i(stall_i), .flush_i(flush_i),
        .id_ready_o(id_ready_o), .ex_valid_o(ex_valid_o), .reg_write_o(reg_write_o), .mem_write_o(mem_write_o),
        .branch_o(branch_o), .load_o(load_o), .store_o(store_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
        .alu_control_o(alu_control_o), .result_src_o(result_src_o), .branch_type_o(branch_type_o), .jump_o(jump_o),
        .imm_src_o(imm_src_o), .addr_ctrl_o(addr_ctrl_o), .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
        .muldiv_op_o(muldiv_op_o), .muldiv_start_o(muldiv_start_o), .muldiv_abort_o(muldiv_abort_o),
        .illegal_o(illegal_o), .busy_o(busy_o)
    );
    decode_ctrl_pipe #(.ENABLE_M(1'b0)) dut_nom (
        .clk(clk), .rst(rst), .instr_i(instr_i), .instr_valid_i(instr_valid_i), .stall_i(stall_i), .flush_i(flush_i),
        .id_ready_o(n_rdy), .ex_valid_o(n_ev), .reg_write_o(n_rw), .mem_write_o(n_mw),
        .branch_o(n_br), .load_o(n_ld), .store_o(n_st), .alu_src_a_o(n_sa), .alu_src_b_o(n_sb),
        .alu_control_o(n_alu), .result_src_o(n_res), .branch_type_o(n_bt), .jump_o(n_jmp),
        .imm_src_o(n_imm), .addr_ctrl_o(n_ac), .rd_o(n_rd), .rs1_o(n_rs1), .rs2_o(n_rs2),
        .muldiv_op_o(n_mop), .muldiv_start_o(n_start), .muldiv_abort_o(n_abort),
        .illegal_o(n_ill), .busy_o(n_busy)
    );

    assign all_o = {ex_valid_o, reg_write_o, mem_write_o, branch_o, load_o, store_o, alu_src_a_o, alu_src_b_o,
                    alu_control_o, result_src_o, branch_type_o, jump_o, imm_src_o, addr_ctrl_o, rd_o, rs1_o, rs2_o,
                    muldiv_op_o, muldiv_start_o, muldiv_abort_o, illegal_o, busy_o};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] ins, input logic v, input logic st, input logic fl);
        @(negedge clk);
        instr_i = ins;
        instr_valid_i = v;
        stall_i = st;
        flush_i = fl;
    endtask

    // a stalled edge keeps the previous bundle, so it is not a new EX transaction
    always @(posedge clk) held <= stall_i && !flush_i && !rst;

    always @(negedge clk) begin
        if (ex_valid_o && !held) begin
            if (q.size() == 0) chk("unexp_ex_valid", 64'(ex_valid_o), 64'd0);
            else begin
                m_e = q.pop_front();
                chk({m_e.nm, ".ctl"}, 64'({reg_write_o, mem_write_o, branch_o, load_o, store_o, alu_src_a_o, alu_src_b_o}), 64'(m_e.f));
                chk({m_e.nm, ".alu"}, 64'(alu_control_o), 64'(m_e.alu));
                chk({m_e.nm, ".res"}, 64'(result_src_o), 64'(m_e.res));
                chk({m_e.nm, ".bt"}, 64'(branch_type_o), 64'(m_e.bt));
                chk({m_e.nm, ".jmp"}, 64'(jump_o), 64'(m_e.jmp));
                chk({m_e.nm, ".imm"}, 64'(imm_src_o), 64'(m_e.imm));
                chk({m_e.nm, ".ac"}, 64'(addr_ctrl_o), 64'(m_e.ac));
                chk({m_e.nm, ".regs"}, 64'({rd_o, rs1_o, rs2_o}), 64'({m_e.rd, m_e.rs1, m_e.rs2}));
                chk({m_e.nm, ".mop"}, 64'(muldiv_op_o), 64'(m_e.mop));
                chk({m_e.nm, ".ill"}, 64'(illegal_o), 64'(m_e.ill));
            end
        end
    end

    initial begin
        tbl[0]  = '{"add",   32'h002081B3, 7'b1000000, 4'h0, 2'd0, 3'd0, 2'd0, 3'd0, 3'd0, 5'd3,  5'd1,  5'd2,  3'd0, 1'b0};
        tbl[1]  = '{"sub",   32'h403100B3, 7'b1000000, 4'h1, 2'd0, 3'd0, 2'd0, 3'd0, 3'd0, 5'd1,  5'd2,  5'd3,  3'd0, 1'b0};
        tbl[2]  = '{"lw",    32'h0040A203, 7'b1001001, 4'h0, 2'd1, 3'd0, 2'd0, 3'd0, 3'd2, 5'd4,  5'd1,  5'd4,  3'd0, 1'b0};
        tbl[3]  = '{"sw",    32'h00512423, 7'b0100101, 4'h0, 2'd0, 3'd0, 2'd0, 3'd1, 3'd2, 5'd8,  5'd2,  5'd5,  3'd0, 1'b0};
        tbl[4]  = '{"lui",   32'h123453B7, 7'b1000001, 4'hF, 2'd0, 3'd0, 2'd0, 3'd4, 3'd0, 5'd7,  5'd8,  5'd3,  3'd0, 1'b0};
        tbl[5]  = '{"jal",   32'h000000EF, 7'b1000000, 4'h0, 2'd2, 3'd0, 2'd1, 3'd3, 3'd0, 5'd1,  5'd0,  5'd0,  3'd0, 1'b0};
        tbl[6]  = '{"slti",  32'hFFF52493, 7'b1000001, 4'h8, 2'd0, 3'd0, 2'd0, 3'd0, 3'd0, 5'd9,  5'd10, 5'd31, 3'd0, 1'b0};
        tbl[7]  = '{"bgeu",  32'h00327063, 7'b0010000, 4'h9, 2'd0, 3'd7, 2'd0, 3'd2, 3'd0, 5'd0,  5'd4,  5'd3,  3'd0, 1'b0};
        tbl[8]  = '{"badf7", 32'h802081B3, 7'b0000000, 4'h0, 2'd0, 3'd0, 2'd0, 3'd0, 3'd0, 5'd3,  5'd1,  5'd2,  3'd0, 1'b1};
        tbl[9]  = '{"ones",  32'hFFFFFFFF, 7'b0000000, 4'h0, 2'd0, 3'd0, 2'd0, 3'd0, 3'd0, 5'd31, 5'd31, 5'd31, 3'd0, 1'b1};
        tbl[10] = '{"mul",   32'h027302B3, 7'b1000000, 4'h0, 2'd3, 3'd0, 2'd0, 3'd0, 3'd0, 5'd5,  5'd6,  5'd7,  3'd0, 1'b0};
        tbl[11] = '{"beq",   32'h00208463, 7'b0010000, 4'h1, 2'd0, 3'd0, 2'd0, 3'd2, 3'd0, 5'd8,  5'd1,  5'd2,  3'd0, 1'b0};
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_outs", 64'(all_o), 64'd0);
        chk("rst_rdy", 64'(id_ready_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("post_rst_rdy", 64'(id_ready_o), 64'd1);
        // back-to-back single-cycle instructions, including illegal ones
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].ins, 1'b1, 1'b0, 1'b0);
            #1 chk({tbl[i].nm, ".rdy"}, 64'(id_ready_o), 64'd1);
            q.push_back(tbl[i]);
        end
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        #1 chk("ones_ev", 64'(ex_valid_o), 64'd1);
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        #1 chk("bubble_ev", 64'(ex_valid_o), 64'd0);
        // mul: two-cycle latency
        drive(tbl[10].ins, 1'b1, 1'b0, 1'b0);
        #1 chk("mul_rdy", 64'(id_ready_o), 64'd1);
        q.push_back(tbl[10]);
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        #1 chk("mul_c1", 64'({muldiv_start_o, busy_o, ex_valid_o, id_ready_o}), 64'b1100);
        chk("nom_mul", 64'({n_ill, n_ev, n_rw, n_start, n_busy}), 64'b11000);
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        #1 chk("mul_c2", 64'({muldiv_start_o, busy_o, ex_valid_o, id_ready_o}), 64'b0100);
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        #1 chk("mul_done", 64'({muldiv_start_o, busy_o, ex_valid_o, id_ready_o}), 64'b0011);
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        #1 chk("mul_ev_pulse", 64'(ex_valid_o), 64'd0);
        // div flushed on the 10th busy cycle
        drive(32'h027342B3, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k < 10; k++) begin
            drive(32'h0, 1'b0, 1'b0, 1'b0);
            #1 if (k == 1 || k == 9) chk($sformatf("div_busy%0d", k), 64'({busy_o, ex_valid_o, muldiv_abort_o, id_ready_o}), 64'b1000);
        end
        drive(32'h0, 1'b0, 1'b0, 1'b1);
        #1 chk("flush_rdy", 64'(id_ready_o), 64'd0);
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        #1 chk("flush_abort", 64'({muldiv_abort_o, busy_o, ex_valid_o, id_ready_o}), 64'b1001);
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        #1 chk("abort_pulse", 64'(muldiv_abort_o), 64'd0);
        // beq then stall with a new instruction presented
        drive(tbl[11].ins, 1'b1, 1'b0, 1'b0);
        q.push_back(tbl[11]);
        for (int k = 0; k < 3; k++) begin
            drive(32'h123453B7, 1'b1, 1'b1, 1'b0);
            #1 chk($sformatf("stall%0d", k), 64'({id_ready_o, ex_valid_o, branch_o, alu_control_o, imm_src_o}), 64'({1'b0, 1'b1, 1'b1, 4'b0001, 3'b010}));
        end
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        #1 chk("stall_end", 64'({ex_valid_o, branch_o, alu_control_o, imm_src_o}), 64'({1'b1, 1'b1, 4'b0001, 3'b010}));
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        #1 chk("stall_noconsume", 64'(ex_valid_o), 64'd0);
        // reset in the middle of a div
        drive(32'h027342B3, 1'b1, 1'b0, 1'b0);
        repeat (5) drive(32'h0, 1'b0, 1'b0, 1'b0);
        #1 chk("pre_rst_busy", 64'(busy_o), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("rst_rdy_low", 64'(id_ready_o), 64'd0);
        @(negedge clk);
        chk("rst_div_outs", 64'(all_o), 64'd0);
        rst = 1'b0;
        #1 chk("rst_div_rdy", 64'(id_ready_o), 64'd1);
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        #1 chk("rst_no_abort", 64'({muldiv_abort_o, busy_o, ex_valid_o}), 64'd0);
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        #1 chk("sb_empty", 64'(q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/decode_ctrl_pipe.md
Name: decode_ctrl_pipe

Overview:
Registered RV32 decode/control stage sitting between the IF/ID register and EX. It decodes an instruction into the team's control bundle and registers it as the ID/EX control register. It also handles stall and flush, flags illegal instructions, and sequences multi-cycle RV32M mul/div ops through a counter-based FSM with a start/abort handshake to the mul/div unit.

Parameters:
ENABLE_M, 1, 1 = decode RV32M (funct7=0000001); 0 = those encodings are illegal
MUL_CYCLES, 2, EX latency of mul/mulh/mulhsu/mulhu; must be >=1
DIV_CYCLES, 33, EX latency of div/divu/rem/remu; must be >=1
CNT_W, $clog2(max(MUL_CYCLES,DIV_CYCLES))+1, localparam counter width

Ports:
clk  in  1  clock
rst  in  1  reset
instr_i  in  32  instruction from IF/ID
instr_valid_i  in  1  instr_i is valid
stall_i  in  1  hazard-unit stall
flush_i  in  1  branch/jump flush
id_ready_o  out  1  instruction accepted this edge
ex_valid_o  out  1  registered bundle valid for EX
reg_write_o, mem_write_o, branch_o, load_o, store_o, alu_src_a_o, alu_src_b_o  out  1 each  control bits
alu_control_o  out  4  ALU op
result_src_o  out  2  00 ALU, 01 mem, 10 PC+4, 11 mul/div
branch_type_o  out  3  funct3 for branches
jump_o  out  2  00 none, 01 JAL, 10 JALR
imm_src_o  out  3  I 000, S 001, B 010, J 011, U 100
addr_ctrl_o  out  3  load/store funct3
rd_o, rs1_o, rs2_o  out  5 each  register indices
muldiv_op_o  out  3  funct3 of M op
muldiv_start_o  out  1  one-cycle start pulse
muldiv_abort_o  out  1  one-cycle abort pulse
illegal_o  out  1  illegal instruction
busy_o  out  1  FSM in MD_BUSY

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: every registered output is 0, state is IDLE, cnt is 0. id_ready_o is forced 0 while rst=1.
- ALU codes: add 0000, sub 0001, and 0010, or 0011, xor 0100, sll 0101, srl 0110, sra 0111, slt 1000, sltu 1001, lui 1111.
- Decoding of R/I/load/store/branch/JAL/JALR/LUI/AUIPC:
  - branches: beq/bne use sub; blt/bge use slt; bltu/bgeu use sltu.
  - AUIPC: alu_src_a_o=1.
  - JALR: add.
- id_ready_o = !rst & state==IDLE & !stall_i & !flush_i. This is combinational.
- Enable gating: reg_write_o, mem_write_o, branch_o, jump_o, load_o and store_o are the registered field AND ex_valid_o.
- Edge priority: rst > flush_i > stall_i > normal.
- flush_i:
  - ex_valid_o and illegal_o go to 0; state goes to IDLE; cnt goes to 0.
  - If state was MD_BUSY, muldiv_abort_o=1 for one cycle.
- IDLE:
  - stall_i: hold everything.
  - Not stalled, instr_valid_i=0: bubble, ex_valid_o goes to 0.
  - Not stalled, instr_valid_i=1, non-M instruction: load the bundle; ex_valid_o goes to 1 (latency of 1 edge).
  - Not stalled, instr_valid_i=1, M op: load the bundle with result_src_o=11, muldiv_start_o=1 (one cycle) and ex_valid_o=0. Set cnt to LAT-1, where LAT is MUL_CYCLES if funct3[2]=0, else DIV_CYCLES. State goes to MD_BUSY.
- MD_BUSY:
  - The bundle is held.
  - If cnt!=0, cnt decrements regardless of stall_i.
  - If cnt==0 and stall_i=0, state goes to IDLE and ex_valid_o goes to 1 for one cycle.
  - If cnt==0 and stall_i=1, wait.
  - Result: ex_valid_o rises LAT edges after the accept edge.
- Illegal instructions (unknown opcode, bad funct7, or M op with ENABLE_M=0): illegal_o=1, ex_valid_o=1, all write enables 0.
- busy_o = (state==MD_BUSY).

Decomposition:
- Package ctrl_pkg holds:
  - opcode constants;
  - enums alu_op_e, imm_src_e, result_src_e, jump_e;
  - struct ctrl_bundle_t.
- Sub-module instr_decode is pure combinational: instr to ctrl_bundle_t plus is_muldiv and illegal.
- The FSM, counter and ID/EX register live in decode_ctrl_pipe.

Test Plan:
- 0x002081B3 (add x3,x1,x2), IDLE -> next edge: ex_valid_o=1, alu_control_o=0000, reg_write_o=1, rd/rs1/rs2=3/1/2, result_src_o=00.
- 0x027302B3 (mul x5,x6,x7), MUL_CYCLES=2 -> muldiv_start_o high 1 cycle; id_ready_o=0 for 2 cycles; ex_valid_o=1 exactly 2 edges after accept; result_src_o=11; muldiv_op_o=000.
- 0x027342B3 (div), DIV_CYCLES=33, flush_i on the 10th busy cycle -> muldiv_abort_o pulses once, busy_o=0, ex_valid_o=0, id_ready_o=1 the next cycle.
- 0x00208463 (beq x1,x2,8) then stall_i=1 for 3 cycles with a new instruction presented -> branch_o=1, alu_control_o=0001, imm_src_o=010 held; new instruction not consumed.
- 0xFFFFFFFF -> illegal_o=1, ex_valid_o=1, reg_write_o=0, mem_write_o=0. With ENABLE_M=0, 0x027302B3 -> illegal_o=1.
- rst asserted mid-div -> next edge all outputs 0, state IDLE, no abort pulse; id_ready_o=1 the first cycle after rst falls.
